rambus_ctrl: RTL and testbench
==============================

Name: rambus_ctrl

Overview:
- Wishbone slave front end that sits directly upstream of the rambus SRAM array.
- Converts classic Wishbone single transfers into correctly timed strobes for four gf180 512x8 SRAM macros, one macro per byte lane; all SRAM controls are active-low.
- Provides byte-lane writes, registered read capture and a one-cycle ack.
- Replaces the present direct tie-off of GWEN/CEN/WEN.

Parameters:
- AW, 9, word-address width (SRAM depth 2^AW words).
- RD_LAT, 1, cycles from the SRAM access edge until Q is valid; legal range 1..3.

Ports:
- rambus_wb_clk_i  in  1  system clock; SRAM macros share it.
- rambus_wb_rst_ni  in  1  asynchronous active-low reset.
- rambus_wb_stb_i  in  1  strobe.
- rambus_wb_cyc_i  in  1  cycle.
- rambus_wb_we_i  in  1  1 = write.
- rambus_wb_sel_i  in  4  byte-lane select; bit i maps to dat[8i+7:8i].
- rambus_wb_dat_i  in  32  write data.
- rambus_wb_addr_i  in  AW+2  byte address; [1:0] ignored, word index = [AW+1:2].
- rambus_wb_ack_o  out  1  transfer acknowledge.
- rambus_wb_dat_o  out  32  read data.
- sram_a_o  out  AW  shared macro address.
- sram_d_o  out  32  write data; byte i goes to macro i.
- sram_q_i  in  32  macro outputs; byte i comes from macro i.
- sram_cen_no  out  4  per-macro chip enable, active-low.
- sram_gwen_no  out  4  per-macro global write enable, active-low.
- sram_wen_no  out  32  per-bit write enable, active-low.

Behaviour:
- Reset state (asynchronous, applied immediately):
  - FSM = IDLE, ack_o = 0, dat_o = 0.
  - cen_no = 4'hF, gwen_no = 4'hF, wen_no = all 1s.
  - a_o = 0, d_o = 0.
- All outputs are registered; no combinational path from Wishbone inputs to any output.
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - On cyc & stb, latch word index, sel, we and dat_i.
  - Go to ACCESS; the SRAM outputs below are loaded on this same edge.
- ACCESS (exactly 1 cycle):
  - cen_no[i] = ~sel[i].
  - gwen_no[i] = ~(we & sel[i]).
  - wen_no[8i+7:8i] = {8{~(we & sel[i])}}.
  - The macro samples at the end of this cycle.
  - Next state is ACK for a write, WAIT for a read.
  - Leaving ACCESS returns cen/gwen/wen to all 1s.
- WAIT:
  - Counts RD_LAT cycles with a 2-bit counter.
  - On the final cycle, dat_o byte i = sram_q_i byte i if sel[i], else 8'h00.
  - Then go to ACK.
- ACK:
  - ack_o = 1 for exactly one cycle, then IDLE.
  - Requests are not sampled in ACK, so a held stb cannot be accepted twice.
- Latency, counting the request-visible cycle as 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT (3 at default).
  - Back-to-back: next request can be accepted in the cycle after ack; minimum spacing is 3 (write) or 4 (read) cycles.
- sel = 0: no macro is enabled, nothing is written, read returns 0; the transfer still acks normally.
- cyc dropped after acceptance:
  - An issued SRAM access completes; a write still lands.
  - ack_o is suppressed: ACK asserts ack only if cyc is high in the preceding cycle, otherwise ACK goes straight to IDLE with ack 0.
  - dat_o is still updated.
- Reset mid-operation: all enables deassert asynchronously; any in-flight write may or may not land; FSM is in IDLE on the first edge after release.
- dat_o holds its last captured value between reads; writes do not modify it.
- Address wrap: only bits [AW+1:2] are used, so with AW = 9, byte address 0x800 aliases 0x000.

Test Plan:
- Full-word write then read: write 0xDEADBEEF to 0x010 with sel=F, read 0x010 with sel=F -> read data 0xDEADBEEF.
  - Write ack 2 cycles after request; read ack 3 cycles after request.
  - In the write ACCESS cycle: gwen_no = 0, wen_no = 0, a_o = 0x004.
- Byte-lane merge: preload 0x11223344 at 0x020, write 0x0000AA00 with sel=0010, read with sel=F -> 0x1122AA44.
  - In that write's ACCESS cycle: cen_no = 4'b1101, wen_no[15:8] = 0, all other wen_no bits = 1.
- Partial read and sel=0:
  - Read 0x020 with sel=1001 -> 0x11000044.
  - Read with sel=0 -> cen_no stays F, dat_o = 0, ack still issued.
- Abort: drop cyc in the ACCESS cycle of a write of 0x55 -> no ack for that transfer; a later read of the same address returns 0x55.
- Reset mid-read: assert rst_n low during WAIT -> ack_o = 0, dat_o = 0 and cen_no = F immediately; the first request after release completes with normal latency.
- Back-to-back with stb held through ack: exactly one ack per transfer; RD_LAT=3 build gives read ack 5 cycles after request.

Source files
------------

// File: rtl/rambus_ctrl.sv
// Wishbone classic slave driving four 512x8 active-low SRAM macros, one per byte lane.
// Every output is registered; a 4-state FSM sequences access, read wait and ack.
module rambus_ctrl #(
  parameter int AW     = 9,
  parameter int RD_LAT = 1
) (
  input  logic          rambus_wb_clk_i,
  input  logic          rambus_wb_rst_ni,
  input  logic          rambus_wb_stb_i,
  input  logic          rambus_wb_cyc_i,
  input  logic          rambus_wb_we_i,
  input  logic [3:0]    rambus_wb_sel_i,
  input  logic [31:0]   rambus_wb_dat_i,
  input  logic [AW+1:0] rambus_wb_addr_i,
  output logic          rambus_wb_ack_o,
  output logic [31:0]   rambus_wb_dat_o,
  output logic [AW-1:0] sram_a_o,
  output logic [31:0]   sram_d_o,
  input  logic [31:0]   sram_q_i,
  output logic [3:0]    sram_cen_no,
  output logic [3:0]    sram_gwen_no,
  output logic [31:0]   sram_wen_no
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;
  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [AW-1:0] a_q, a_d;
  logic [31:0]   d_q, d_d;
  logic [3:0]    cen_q, cen_d;
  logic [3:0]    gwen_q, gwen_d;
  logic [31:0]   wen_q, wen_d;
  logic          addr_unused_s;

  assign addr_unused_s = ^rambus_wb_addr_i[1:0];

  // Next-state and output-register logic; SRAM strobes only live for the ACCESS cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    a_d     = a_q;
    d_d     = d_q;
    cen_d   = 4'hF;
    gwen_d  = 4'hF;
    wen_d   = {32{1'b1}};
    case (state_q)
      S_IDLE: begin
        if (rambus_wb_cyc_i && rambus_wb_stb_i) begin
          state_d = S_ACCESS;
          sel_d   = rambus_wb_sel_i;
          we_d    = rambus_wb_we_i;
          a_d     = rambus_wb_addr_i[AW+1:2];
          d_d     = rambus_wb_dat_i;
          cen_d   = ~rambus_wb_sel_i;
          gwen_d  = ~(rambus_wb_sel_i & {4{rambus_wb_we_i}});
          for (int i = 0; i < 4; i++) begin
            wen_d[8*i +: 8] = {8{~(rambus_wb_we_i & rambus_wb_sel_i[i])}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        cnt_d = 2'd0;
        if (we_q) begin
          state_d = S_ACK;
          ack_d   = rambus_wb_cyc_i;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_ACK;
          ack_d   = rambus_wb_cyc_i;
          for (int i = 0; i < 4; i++) begin
            dat_d[8*i +: 8] = sel_q[i] ? sram_q_i[8*i +: 8] : 8'h00;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear to the idle/deasserted state
  always_ff @(posedge rambus_wb_clk_i or negedge rambus_wb_rst_ni) begin
    if (!rambus_wb_rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= 32'h0000_0000;
      a_q     <= {AW{1'b0}};
      d_q     <= 32'h0000_0000;
      cen_q   <= 4'hF;
      gwen_q  <= 4'hF;
      wen_q   <= {32{1'b1}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      a_q     <= a_d;
      d_q     <= d_d;
      cen_q   <= cen_d;
      gwen_q  <= gwen_d;
      wen_q   <= wen_d;
    end
  end

  assign rambus_wb_ack_o = ack_q;
  assign rambus_wb_dat_o = dat_q;
  assign sram_a_o        = a_q;
  assign sram_d_o        = d_q;
  assign sram_cen_no     = cen_q;
  assign sram_gwen_no    = gwen_q;
  assign sram_wen_no     = wen_q;

endmodule

// File: tb/tb_rambus_ctrl.sv
// Directed bench for rambus_ctrl with a behavioural model of the four byte-lane SRAM macros.
module tb_rambus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [10:0] addr;
  logic        ack;
  logic [31:0] rdat;
  logic [8:0]  sram_a;
  logic [31:0] sram_d, sram_q, sram_wen;
  logic [3:0]  sram_cen, sram_gwen;
  logic [7:0]  mem [4][512];
  int          checks = 0;
  int          errors = 0;

  rambus_ctrl dut (
    .rambus_wb_clk_i (clk),
    .rambus_wb_rst_ni(rst_n),
    .rambus_wb_stb_i (stb),
    .rambus_wb_cyc_i (cyc),
    .rambus_wb_we_i  (we),
    .rambus_wb_sel_i (sel),
    .rambus_wb_dat_i (wdat),
    .rambus_wb_addr_i(addr),
    .rambus_wb_ack_o (ack),
    .rambus_wb_dat_o (rdat),
    .sram_a_o        (sram_a),
    .sram_d_o        (sram_d),
    .sram_q_i        (sram_q),
    .sram_cen_no     (sram_cen),
    .sram_gwen_no    (sram_gwen),
    .sram_wen_no     (sram_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: per-bit write on gwen low, otherwise a one-cycle registered read
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!sram_cen[i]) begin
        if (!sram_gwen[i])
          mem[i][sram_a] <= (mem[i][sram_a] & sram_wen[8*i +: 8]) |
                            (sram_d[8*i +: 8] & ~sram_wen[8*i +: 8]);
        else
          sram_q[8*i +: 8] <= mem[i][sram_a];
      end
    end
  end

  task automatic do_xfer(input logic t_we, input logic [3:0] t_sel, input logic [10:0] t_addr,
                         input logic [31:0] t_dat, input logic drop_cyc, output int lat,
                         output logic [31:0] rd, output logic [3:0] a_cen, output logic [3:0] a_gwen,
                         output logic [31:0] a_wen, output logic [8:0] a_a, output logic [31:0] a_d);
    cyc = 1'b1; stb = 1'b1; we = t_we; sel = t_sel; addr = t_addr; wdat = t_dat;
    lat = -1; rd = 32'h0; a_cen = 4'h0; a_gwen = 4'h0; a_wen = 32'h0; a_a = 9'h0; a_d = 32'h0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        a_cen = sram_cen; a_gwen = sram_gwen; a_wen = sram_wen; a_a = sram_a; a_d = sram_d;
        if (drop_cyc) begin cyc = 1'b0; stb = 1'b0; end
      end
      if (ack === 1'b1) begin
        lat = n; rd = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
    checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", rdat); end
    checks++; if (sram_cen !== 4'hF) begin errors++; $display("FAIL reset_cen got %h exp f", sram_cen); end
    checks++; if (sram_gwen !== 4'hF) begin errors++; $display("FAIL reset_gwen got %h exp f", sram_gwen); end
    checks++; if (sram_wen !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_wen got %h exp ffffffff", sram_wen); end
    checks++; if (sram_a !== 9'h0) begin errors++; $display("FAIL reset_a got %h exp 0", sram_a); end
    checks++; if (sram_d !== 32'h0) begin errors++; $display("FAIL reset_d got %h exp 0", sram_d); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_word();
    int lat; logic [31:0] rd, aw, ad; logic [3:0] ac, ag; logic [8:0] aa;
    do_xfer(1'b1, 4'hF, 11'h010, 32'hDEAD_BEEF, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (lat != 2) begin errors++; $display("FAIL full_wr_lat got %0d exp 2", lat); end
    checks++; if (ag !== 4'h0) begin errors++; $display("FAIL full_wr_gwen got %h exp 0", ag); end
    checks++; if (aw !== 32'h0) begin errors++; $display("FAIL full_wr_wen got %h exp 0", aw); end
    checks++; if (aa !== 9'h004) begin errors++; $display("FAIL full_wr_a got %h exp 004", aa); end
    checks++; if (ad !== 32'hDEAD_BEEF) begin errors++; $display("FAIL full_wr_d got %h exp deadbeef", ad); end
    do_xfer(1'b0, 4'hF, 11'h010, 32'h0, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (lat != 3) begin errors++; $display("FAIL full_rd_lat got %0d exp 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL full_rd_dat got %h exp deadbeef", rd); end
    checks++; if (ag !== 4'hF) begin errors++; $display("FAIL full_rd_gwen got %h exp f", ag); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got %b exp 0", ack); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_lane();
    int lat; logic [31:0] rd, aw, ad; logic [3:0] ac, ag; logic [8:0] aa;
    do_xfer(1'b1, 4'hF, 11'h020, 32'h1122_3344, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    do_xfer(1'b1, 4'b0010, 11'h020, 32'h0000_AA00, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (ac !== 4'b1101) begin errors++; $display("FAIL lane_cen got %b exp 1101", ac); end
    checks++; if (ag !== 4'b1101) begin errors++; $display("FAIL lane_gwen got %b exp 1101", ag); end
    checks++; if (aw !== 32'hFFFF_00FF) begin errors++; $display("FAIL lane_wen got %h exp ffff00ff", aw); end
    checks++; if (rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dat_hold got %h exp deadbeef", rdat); end
    do_xfer(1'b0, 4'hF, 11'h020, 32'h0, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (rd !== 32'h1122_AA44) begin errors++; $display("FAIL lane_merge got %h exp 1122aa44", rd); end
  endtask

  task automatic test_partial_sel0();
    int lat; logic [31:0] rd, aw, ad; logic [3:0] ac, ag; logic [8:0] aa;
    do_xfer(1'b0, 4'b1001, 11'h020, 32'h0, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (rd !== 32'h1100_0044) begin errors++; $display("FAIL partial_rd got %h exp 11000044", rd); end
    checks++; if (ac !== 4'b0110) begin errors++; $display("FAIL partial_cen got %b exp 0110", ac); end
    do_xfer(1'b0, 4'b0000, 11'h020, 32'h0, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (ac !== 4'hF) begin errors++; $display("FAIL sel0_cen got %h exp f", ac); end
    checks++; if (lat != 3) begin errors++; $display("FAIL sel0_lat got %0d exp 3", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sel0_dat got %h exp 0", rd); end
  endtask

  task automatic test_addr_high();
    int lat; logic [31:0] rd, aw, ad; logic [3:0] ac, ag; logic [8:0] aa;
    do_xfer(1'b1, 4'hF, 11'h7FF, 32'h0BAD_CAFE, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (aa !== 9'h1FF) begin errors++; $display("FAIL high_a got %h exp 1ff", aa); end
    do_xfer(1'b0, 4'hF, 11'h7FC, 32'h0, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (rd !== 32'h0BAD_CAFE) begin errors++; $display("FAIL high_rd got %h exp 0badcafe", rd); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd, aw, ad; logic [3:0] ac, ag; logic [8:0] aa;
    do_xfer(1'b1, 4'hF, 11'h030, 32'h0000_0055, 1'b1, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (lat != -1) begin errors++; $display("FAIL abort_noack got lat %0d exp none", lat); end
    do_xfer(1'b0, 4'hF, 11'h030, 32'h0, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (rd !== 32'h0000_0055) begin errors++; $display("FAIL abort_landed got %h exp 00000055", rd); end
  endtask

  task automatic test_reset_mid_read();
    int lat; logic [31:0] rd, aw, ad; logic [3:0] ac, ag; logic [8:0] aa;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 11'h020;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL midrst_ack got %b exp 0", ack); end
    checks++; if (rdat !== 32'h0) begin errors++; $display("FAIL midrst_dat got %h exp 0", rdat); end
    checks++; if (sram_cen !== 4'hF) begin errors++; $display("FAIL midrst_cen got %h exp f", sram_cen); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_xfer(1'b0, 4'hF, 11'h010, 32'h0, 1'b0, lat, rd, ac, ag, aw, aa, ad);
    checks++; if (lat != 3) begin errors++; $display("FAIL postrst_lat got %0d exp 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL postrst_dat got %h exp deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] hist;
    hist = 9'h0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; addr = 11'h040; wdat = 32'hCAFE_F00D;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      hist[c] = ack;
      if (c == 8) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
    end
    @(posedge clk);
    #1;
    checks++; if (hist !== 9'h124) begin errors++; $display("FAIL b2b_wr_acks got %b exp 100100100", hist); end
    hist = 9'h0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      hist[c] = ack;
      if (c == 8) begin cyc = 1'b0; stb = 1'b0; end
    end
    @(posedge clk);
    #1;
    checks++; if (hist !== 9'h088) begin errors++; $display("FAIL b2b_rd_acks got %b exp 010001000", hist); end
    checks++; if (rdat !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rd_dat got %h exp cafef00d", rdat); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 512; j++)
        mem[i][j] = 8'h00;
    sram_q = 32'h0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = 32'h0; addr = 11'h0;
    test_reset();
    test_full_word();
    test_byte_lane();
    test_partial_sel0();
    test_addr_high();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
